flop_pipe: RTL and testbench

- Parametrised successor to the single enable-flop.
- A DEPTH-stage, WIDTH-bit register pipeline with a global advance enable and per-stage valid tracking.
- Adds synchronous flush, an occupancy counter and optional zeroing of invalid stages.
- Used as a generic retiming/delay element between datapath blocks wherever a fixed, stallable latency is required.

---
 rtl/flop_pipe_pkg.sv | 12 +
 rtl/flop_pipe_if.sv | 31 +++
 rtl/flop_pipe_chk.sv | 28 ++
 rtl/flop_pipe_stage.sv | 59 +++++
 rtl/flop_pipe.sv | 92 +++++++++
 tb/tb_flop_pipe.sv | 213 +++++++++++++++++++++
 6 files changed

// File: rtl/flop_pipe_pkg.sv
// Shared definitions for the flop_pipe retiming pipeline.
package flop_pkg;

  // Bit value replicated across WIDTH to form the default stage reset value.
  localparam bit RESET_BIT_DEFAULT = 1'b0;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_pipe_if.sv
// Handshake/data bundle between a producer and a flop_pipe instance.
interface flop_pipe_if
  import flop_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) ();

  localparam int OCC_W = occ_w(DEPTH);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic [OCC_W-1:0] occ;

  // Producer side: drives the advance/flush controls and the input word.
  modport master (
    output en, flush, in_valid, in,
    input  out_valid, out, occ
  );

  // Pipeline side: consumes controls and input, presents the delayed word.
  modport slave (
    input  en, flush, in_valid, in,
    output out_valid, out, occ
  );

endinterface

// File: rtl/flop_pipe_chk.sv
// Invariant checker for flop_pipe: the occupancy counter must track the
// number of valid stages exactly, stay in range and never go unknown.
module flop_pipe_chk #(
  parameter int DEPTH = 3,
  parameter int OCC_W = 2
) (
  input logic             clk,
  input logic             rst,
  input logic [DEPTH-1:0] valid,
  input logic [OCC_W-1:0] occ
);

  // Occupancy equals the population count of the stage valids.
  a_occ_popcount : assert property (
    @(posedge clk) disable iff (rst) (occ == OCC_W'($countones(valid)))
  );

  // Occupancy never exceeds the number of stages.
  a_occ_range : assert property (
    @(posedge clk) disable iff (rst) (int'(occ) <= DEPTH)
  );

  // Control state is always known once reset has been applied.
  a_no_x : assert property (
    @(posedge clk) disable iff (rst) (!$isunknown({valid, occ}))
  );

endmodule

// File: rtl/flop_pipe_stage.sv
// One data+valid register stage of flop_pipe with hold, flush and
// optional zeroing of data whenever the stage captures an invalid word.
module flop_stage
  import flop_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{RESET_BIT_DEFAULT}},
  parameter bit               CLR_INVALID = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic [WIDTH-1:0] data_next_s;
  logic             valid_next_s;

  // Next-state selection: flush clears, enable captures, otherwise hold.
  always_comb begin
    data_next_s  = data_r;
    valid_next_s = valid_r;
    if (flush) begin
      data_next_s  = RESET_VAL;
      valid_next_s = 1'b0;
    end else if (en) begin
      valid_next_s = d_valid;
      if (CLR_INVALID && !d_valid) begin
        data_next_s = RESET_VAL;
      end else begin
        data_next_s = d;
      end
    end else begin
      data_next_s  = data_r;
      valid_next_s = valid_r;
    end
  end

  // Stage registers; synchronous reset overrides flush and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= RESET_VAL;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_next_s;
      valid_r <= valid_next_s;
    end
  end

  assign q       = data_r;
  assign q_valid = valid_r;

endmodule

// File: rtl/flop_pipe.sv
// DEPTH-stage, WIDTH-bit stallable register pipeline with per-stage valids,
// synchronous flush and a registered occupancy counter.
module flop_pipe
  import flop_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{RESET_BIT_DEFAULT}},
  parameter bit               CLR_INVALID = 1'b0
) (
  input logic        clk,
  input logic        rst,
  flop_pipe_if.slave bus
);

  localparam int OCC_W = occ_w(DEPTH);

  // chain_*[k] feeds stage k; chain_*[k+1] is the output of stage k.
  logic [WIDTH-1:0] chain_data_s  [DEPTH+1];
  logic             chain_valid_s [DEPTH+1];
  logic [DEPTH-1:0] valid_vec_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_next_s;

  assign chain_data_s[0]  = bus.in;
  assign chain_valid_s[0] = bus.in_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    flop_stage #(
      .WIDTH       (WIDTH),
      .RESET_VAL   (RESET_VAL),
      .CLR_INVALID (CLR_INVALID)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .flush   (bus.flush),
      .d       (chain_data_s[k]),
      .d_valid (chain_valid_s[k]),
      .q       (chain_data_s[k+1]),
      .q_valid (chain_valid_s[k+1])
    );
  end

  // Gather stage valids into a vector for the invariant checker.
  always_comb begin
    valid_vec_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      valid_vec_s[k] = chain_valid_s[k+1];
    end
  end

  // Occupancy update: a word entering and one leaving on the same edge cancel.
  always_comb begin
    occ_next_s = occ_r;
    if (bus.flush) begin
      occ_next_s = {OCC_W{1'b0}};
    end else if (bus.en) begin
      case ({bus.in_valid, chain_valid_s[DEPTH]})
        2'b10:   occ_next_s = occ_r + OCC_W'(1);
        2'b01:   occ_next_s = occ_r - OCC_W'(1);
        default: occ_next_s = occ_r;
      endcase
    end else begin
      occ_next_s = occ_r;
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      occ_r <= occ_next_s;
    end
  end

  assign bus.out       = chain_data_s[DEPTH];
  assign bus.out_valid = chain_valid_s[DEPTH];
  assign bus.occ       = occ_r;

  flop_pipe_chk #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .valid (valid_vec_s),
    .occ   (occ_r)
  );

endmodule

// File: tb/tb_flop_pipe.sv
// Self-checking bench for flop_pipe: a DEPTH=3 instance and a DEPTH=1
// CLR_INVALID=1 instance, checked against a history-queue model every cycle
// plus hand-computed expectations at key points.
module tb_flop_pipe;
  import flop_pkg::*;

  localparam int DA = 3;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  flop_pipe_if #(.WIDTH(4), .DEPTH(DA)) ifa ();
  flop_pipe_if #(.WIDTH(4), .DEPTH(DB)) ifb ();

  flop_pipe #(.WIDTH(4), .DEPTH(DA), .RESET_VAL(4'h0), .CLR_INVALID(1'b0)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  flop_pipe #(.WIDTH(4), .DEPTH(DB), .RESET_VAL(4'h0), .CLR_INVALID(1'b1)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: each pipeline is the list of the last DEPTH words accepted on
  // enabled edges since the latest reset/flush; the oldest is at the output.
  bit [4:0] hist_a[$];
  bit [4:0] hist_b[$];
  bit       model_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      hist_a.delete();
      hist_b.delete();
      model_ready = 1'b1;
    end else begin
      if (ifa.flush) hist_a.delete();
      else if (ifa.en) begin
        hist_a.push_back({ifa.in_valid, ifa.in});
        if (hist_a.size() > DA) void'(hist_a.pop_front());
      end
      if (ifb.flush) hist_b.delete();
      else if (ifb.en) begin
        hist_b.push_back({ifb.in_valid, ifb.in});
        if (hist_b.size() > DB) void'(hist_b.pop_front());
      end
    end
  end

  logic       exp_ov_a, exp_ov_b;
  logic [3:0] exp_out_a, exp_out_b;
  int         exp_occ_a, exp_occ_b;

  // Compare process: both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    if (model_ready) begin
      exp_ov_a  = (hist_a.size() == DA) ? hist_a[0][4]   : 1'b0;
      exp_out_a = (hist_a.size() == DA) ? hist_a[0][3:0] : 4'h0;
      exp_occ_a = 0;
      foreach (hist_a[i]) exp_occ_a += int'(hist_a[i][4]);
      chk("a_out_valid", 32'(ifa.out_valid), 32'(exp_ov_a));
      if (exp_ov_a || hist_a.size() < DA) chk("a_out", 32'(ifa.out), 32'(exp_out_a));
      chk("a_occ", 32'(ifa.occ), 32'(exp_occ_a));

      exp_ov_b  = (hist_b.size() == DB) ? hist_b[0][4] : 1'b0;
      exp_out_b = 4'h0;
      if (hist_b.size() == DB && hist_b[0][4]) exp_out_b = hist_b[0][3:0];
      exp_occ_b = 0;
      foreach (hist_b[i]) exp_occ_b += int'(hist_b[i][4]);
      chk("b_out_valid", 32'(ifb.out_valid), 32'(exp_ov_b));
      chk("b_out", 32'(ifb.out), 32'(exp_out_b));
      chk("b_occ", 32'(ifb.occ), 32'(exp_occ_b));
    end
  end

  task automatic cyc_a(input logic e, input logic f, input logic v, input logic [3:0] d);
    @(negedge clk);
    ifa.en = e; ifa.flush = f; ifa.in_valid = v; ifa.in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic e, input logic f, input logic v, input logic [3:0] d);
    @(negedge clk);
    ifb.en = e; ifb.flush = f; ifb.in_valid = v; ifb.in = d;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] words   [5] = '{4'h3, 4'h7, 4'hA, 4'h1, 4'hE};
  int         s_occ   [8] = '{1, 2, 3, 3, 3, 2, 1, 0};
  logic [3:0] b_dat   [4] = '{4'h2, 4'hB, 4'h4, 4'hC};
  logic       b_val   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int         b_occ   [7] = '{1, 1, 2, 1, 1, 0, 0};
  logic       b_ov    [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    ifa.en = 1'b0; ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.in = 4'h0;
    ifb.en = 1'b0; ifb.flush = 1'b0; ifb.in_valid = 1'b0; ifb.in = 4'h0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out", 32'(ifa.out), 32'h0);
    chk("rst_a_ov", 32'(ifa.out_valid), 32'h0);
    chk("rst_a_occ", 32'(ifa.occ), 32'h0);
    chk("rst_b_ov", 32'(ifb.out_valid), 32'h0);
    chk("rst_b_occ", 32'(ifb.occ), 32'h0);

    // First word after reset emerges on the 3rd enabled edge.
    rst = 1'b0;
    cyc_a(1'b1, 1'b0, 1'b1, 4'hF);
    chk("rf_e1_ov", 32'(ifa.out_valid), 32'h0);
    chk("rf_e1_occ", 32'(ifa.occ), 32'h1);
    cyc_a(1'b1, 1'b0, 1'b1, 4'hF);
    cyc_a(1'b1, 1'b0, 1'b1, 4'hF);
    chk("rf_e3_out", 32'(ifa.out), 32'hF);
    chk("rf_e3_ov", 32'(ifa.out_valid), 32'h1);
    chk("rf_e3_occ", 32'(ifa.occ), 32'h3);
    cyc_a(1'b1, 1'b1, 1'b0, 4'h0);
    chk("fl0_occ", 32'(ifa.occ), 32'h0);
    chk("fl0_ov", 32'(ifa.out_valid), 32'h0);

    // Stream of five words followed by three bubbles.
    for (int i = 0; i < 8; i++) begin
      if (i < 5) cyc_a(1'b1, 1'b0, 1'b1, words[i]);
      else       cyc_a(1'b1, 1'b0, 1'b0, 4'h0);
      chk("st_occ", 32'(ifa.occ), 32'(s_occ[i]));
      chk("st_ov", 32'(ifa.out_valid), (i >= 2 && i <= 6) ? 32'h1 : 32'h0);
      if (i >= 2 && i <= 6) chk("st_out", 32'(ifa.out), 32'(words[i-2]));
    end

    // Stall: two words loaded, four disabled edges with junk input.
    cyc_a(1'b1, 1'b0, 1'b1, 4'h5);
    cyc_a(1'b1, 1'b0, 1'b1, 4'h6);
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b0, 1'b0, 1'b1, 4'hF);
      chk("stall_occ", 32'(ifa.occ), 32'h2);
      chk("stall_ov", 32'(ifa.out_valid), 32'h0);
    end
    cyc_a(1'b1, 1'b0, 1'b0, 4'h0);
    chk("stall_out5", 32'(ifa.out), 32'h5);
    chk("stall_ov5", 32'(ifa.out_valid), 32'h1);
    cyc_a(1'b1, 1'b0, 1'b0, 4'h0);
    chk("stall_out6", 32'(ifa.out), 32'h6);
    chk("stall_ov6", 32'(ifa.out_valid), 32'h1);
    cyc_a(1'b1, 1'b0, 1'b0, 4'h0);
    chk("stall_drain", 32'(ifa.out_valid), 32'h0);

    // Flush with a simultaneous valid input: 9 must never appear.
    cyc_a(1'b1, 1'b0, 1'b1, 4'h1);
    cyc_a(1'b1, 1'b0, 1'b1, 4'h2);
    cyc_a(1'b1, 1'b0, 1'b1, 4'h3);
    chk("pf_occ", 32'(ifa.occ), 32'h3);
    chk("pf_out", 32'(ifa.out), 32'h1);
    cyc_a(1'b1, 1'b1, 1'b1, 4'h9);
    chk("fl_occ", 32'(ifa.occ), 32'h0);
    chk("fl_ov", 32'(ifa.out_valid), 32'h0);
    chk("fl_out", 32'(ifa.out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b1, 1'b0, 1'b0, 4'h0);
      chk("fl_ov_after", 32'(ifa.out_valid), 32'h0);
      chk("fl_out_after", 32'(ifa.out), 32'h0);
    end

    // Bubbles: valid pattern 1,0,1,0 then drain.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) cyc_a(1'b1, 1'b0, b_val[i], b_dat[i]);
      else       cyc_a(1'b1, 1'b0, 1'b0, 4'h0);
      chk("bub_occ", 32'(ifa.occ), 32'(b_occ[i]));
      chk("bub_ov", 32'(ifa.out_valid), 32'(b_ov[i]));
      if (i == 2) chk("bub_out2", 32'(ifa.out), 32'h2);
      if (i == 4) chk("bub_out4", 32'(ifa.out), 32'h4);
    end
    ifa.en = 1'b0;

    // DEPTH=1 with CLR_INVALID=1.
    cyc_b(1'b1, 1'b0, 1'b0, 4'h7);
    chk("b1_out", 32'(ifb.out), 32'h0);
    chk("b1_ov", 32'(ifb.out_valid), 32'h0);
    chk("b1_occ", 32'(ifb.occ), 32'h0);
    cyc_b(1'b1, 1'b0, 1'b1, 4'h8);
    chk("b2_out", 32'(ifb.out), 32'h8);
    chk("b2_ov", 32'(ifb.out_valid), 32'h1);
    chk("b2_occ", 32'(ifb.occ), 32'h1);
    cyc_b(1'b0, 1'b0, 1'b0, 4'h3);
    chk("b_hold_out", 32'(ifb.out), 32'h8);
    chk("b_hold_occ", 32'(ifb.occ), 32'h1);
    cyc_b(1'b1, 1'b0, 1'b0, 4'h5);
    chk("b_clr_out", 32'(ifb.out), 32'h0);
    chk("b_clr_occ", 32'(ifb.occ), 32'h0);
    cyc_b(1'b1, 1'b0, 1'b1, 4'hC);
    cyc_b(1'b1, 1'b1, 1'b1, 4'hD);
    chk("b_fl_out", 32'(ifb.out), 32'h0);
    chk("b_fl_ov", 32'(ifb.out_valid), 32'h0);
    cyc_b(1'b0, 1'b0, 1'b0, 4'h0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
